dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DMEM_ADDR_WIDTH, default 12, byte-address width of the dmem.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive p1 wait cycles before a forced p1 grant.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  clock
- rst_i  in  1  async reset, active-high
- p0_req_i  in  1  core LSU request
- p0_we_i  in  1  write (1) / read (0)
- p0_sz_i  in  2  size: 00 byte, 01 half, 10 word
- p0_addr_i  in  DMEM_ADDR_WIDTH  byte address
- p0_wdata_i  in  32  store data
- p0_gnt_o  out  1  request accepted this cycle
- p0_rvalid_o  out  1  response valid
- p0_rdata_o  out  32  load data
- p1_req_i, p1_we_i, p1_sz_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o: same widths and meanings, external/debug port
- p1_lock_i  in  1  hold grant on p1 for a burst
- mem_rd_en_o  out  1  dmem read enable
- mem_wr_en_o  out  1  dmem write enable
- mem_sz_o  out  2  dmem size
- mem_addr_o  out  DMEM_ADDR_WIDTH  dmem address
- mem_din_o  out  32  dmem write data
- mem_dout_i  in  32  dmem combinational read data

Function
REQ-005 SHALL grant at most one port per cycle; gnt is combinational from req and state in the same cycle.
REQ-006 SHALL drive mem_* from the granted port in the grant cycle; with no grant, mem_rd_en_o=mem_wr_en_o=0 and mem_addr_o/mem_din_o/mem_sz_o=0.
REQ-007 SHALL assert mem_rd_en_o for a granted read, mem_wr_en_o for a granted write, never both.
REQ-008 SHALL register a granted read's mem_dout_i into pX_rdata_o and pulse pX_rvalid_o for exactly one cycle, the cycle after grant (latency 1).
REQ-009 SHALL pulse pX_rvalid_o one cycle after a granted write as acknowledge, with pX_rdata_o=0.
REQ-010 SHALL hold pX_rdata_o between responses; rvalid of the non-granted port SHALL be 0.
REQ-011 SHALL sustain back-to-back grants every cycle (throughput 1 access/cycle).
REQ-012 SHALL implement FSM states ARB and LOCK_P1; ARB->LOCK_P1 when p1 granted with p1_lock_i=1; LOCK_P1->ARB when p1_req_i=0 or a granted p1 access has p1_lock_i=0.
REQ-013 SHALL in LOCK_P1 grant only p1 (p0_gnt_o=0 even if p0_req_i=1).
REQ-014 SHALL in ARB with both requesting use the priority policy (REQ-020/021).
REQ-015 SHALL count consecutive cycles p1_req_i=1 without p1 grant, saturating at STARVE_LIMIT; cleared on p1 grant or p1_req_i=0.
REQ-016 SHALL when count equals STARVE_LIMIT grant p1 over p0 that cycle.
REQ-017 SHALL pass pX_sz_i unchanged; unaligned addresses forwarded as-is (dmem handles them).

Reset
REQ-018 SHALL on rst_i=1 immediately force: state ARB, starvation count 0, p0/p1_rvalid_o=0, p0/p1_rdata_o=0, round-robin pointer to p0.
REQ-019 SHALL on reset mid-access drop the pending response (no rvalid after reset release).

Configuration
REQ-020 Without DMEM_ARB_RR_EN: fixed priority, p0 over p1 (subject to REQ-016).
REQ-021 With DMEM_ARB_RR_EN: round-robin; pointer flips to the other port after every contested grant; starvation counter still present but never reaches limit.

Structure
REQ-022 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in shared package dmem_pkg.
REQ-023 SHALL isolate priority/round-robin selection in sub-module dmem_arb_sel.

Verification
REQ-024 p0 read addr 0x010 alone -> p0_gnt_o same cycle, mem_rd_en_o=1, p0_rvalid_o next cycle with rdata=mem_dout_i.
REQ-025 Both request every cycle, no RR -> p0 granted 8 cycles, p1 granted 9th cycle, pattern repeats.
REQ-026 DMEM_ARB_RR_EN, both request continuously -> grants alternate p0,p1,p0,p1.
REQ-027 p1 write 0xDEADBEEF word with lock=1 for 3 accesses, p0 requesting -> p0_gnt_o=0 for 3 cycles, then p0 granted.
REQ-028 rst_i asserted cycle after p0 read grant -> p0_rvalid_o=0, rdata=0, state ARB.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory arbiter.
// Holds the access-size codes, the arbiter FSM state enum and the port id
// used by the round-robin pointer.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ARB     = 1'b0,
    LOCK_P1 = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_P0 = 1'b0,
    PORT_P1 = 1'b1
  } port_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// dmem_arb_sel: combinational grant selection between p0 and p1.
// Build option DMEM_ARB_RR_EN: contested cycles follow the round-robin pointer
// instead of the fixed p0-over-p1 priority. Starvation relief and the p1 lock
// override both policies.
module dmem_arb_sel
  import dmem_pkg::*;
(
  input  logic  p0_req,
  input  logic  p1_req,
  input  logic  locked,
  input  logic  starved,
`ifdef DMEM_ARB_RR_EN
  input  port_t rr_ptr,
`endif
  output logic  gnt0,
  output logic  gnt1
);

  // Pick at most one port per cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked) begin
      gnt1 = p1_req;
    end else if (p0_req && p1_req) begin
      if (starved) begin
        gnt1 = 1'b1;
`ifdef DMEM_ARB_RR_EN
      end else if (rr_ptr == PORT_P1) begin
        gnt1 = 1'b1;
`endif
      end else begin
        gnt0 = 1'b1;
      end
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-cycle data memory.
// p0 is the core LSU, p1 the external/debug port. One access per cycle,
// responses one cycle after grant. p1 can lock the memory for a burst and
// is protected from starvation under fixed priority.
// Build option DMEM_ARB_RR_EN: round-robin between contending ports
// (default: fixed priority, p0 over p1).
//
// state   | meaning
// ARB     | normal arbitration between p0 and p1
// LOCK_P1 | p1 holds the memory for a locked burst, p0 is blocked
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       p0_req_i,
  input  logic                       p0_we_i,
  input  logic [1:0]                 p0_sz_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [31:0]                p0_wdata_i,
  output logic                       p0_gnt_o,
  output logic                       p0_rvalid_o,
  output logic [31:0]                p0_rdata_o,
  input  logic                       p1_req_i,
  input  logic                       p1_we_i,
  input  logic [1:0]                 p1_sz_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [31:0]                p1_wdata_i,
  output logic                       p1_gnt_o,
  output logic                       p1_rvalid_o,
  output logic [31:0]                p1_rdata_o,
  input  logic                       p1_lock_i,
  output logic                       mem_rd_en_o,
  output logic                       mem_wr_en_o,
  output logic [1:0]                 mem_sz_o,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]                mem_din_o,
  input  logic [31:0]                mem_dout_i
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             gnt0;
  logic             gnt1;
  logic             locked;
  logic             starved;
  logic             contested;
`ifdef DMEM_ARB_RR_EN
  port_t            rr_ptr;
`endif

  assign locked    = (state == LOCK_P1);
  assign starved   = (starve_cnt == CNT_MAX);
  assign contested = p0_req_i && p1_req_i && !locked;

  dmem_arb_sel u_sel (
`ifdef DMEM_ARB_RR_EN
    .rr_ptr  (rr_ptr),
`endif
    .p0_req  (p0_req_i),
    .p1_req  (p1_req_i),
    .locked  (locked),
    .starved (starved),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;

  // Steer the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_sz_o    = SZ_BYTE;
    mem_addr_o  = '0;
    mem_din_o   = '0;
    if (gnt0) begin
      mem_rd_en_o = !p0_we_i;
      mem_wr_en_o = p0_we_i;
      mem_sz_o    = p0_sz_i;
      mem_addr_o  = p0_addr_i;
      mem_din_o   = p0_wdata_i;
    end else if (gnt1) begin
      mem_rd_en_o = !p1_we_i;
      mem_wr_en_o = p1_we_i;
      mem_sz_o    = p1_sz_i;
      mem_addr_o  = p1_addr_i;
      mem_din_o   = p1_wdata_i;
    end
  end

  // Lock FSM, starvation counter, round-robin pointer and registered responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ARB;
      starve_cnt  <= '0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
      p0_rdata_o  <= '0;
      p1_rdata_o  <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr      <= PORT_P0;
`endif
    end else begin
      case (state)
        ARB: begin
          if (gnt1 && p1_lock_i) state <= LOCK_P1;
        end
        LOCK_P1: begin
          if (!p1_req_i || (gnt1 && !p1_lock_i)) state <= ARB;
        end
        default: state <= ARB;
      endcase

      if (!p1_req_i || gnt1) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

`ifdef DMEM_ARB_RR_EN
      if (contested) rr_ptr <= gnt1 ? PORT_P0 : PORT_P1;
`endif

      // Writes are acknowledged with zero data; reads capture the
      // combinational memory output of the grant cycle.
      p0_rvalid_o <= gnt0;
      p1_rvalid_o <= gnt1;
      if (gnt0) p0_rdata_o <= p0_we_i ? 32'h0 : mem_dout_i;
      if (gnt1) p1_rdata_o <= p1_we_i ? 32'h0 : mem_dout_i;
    end
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_contested;
  assign unused_contested = contested;
`endif

endmodule
